// File: rtl/core_bus_xbar_if.sv
// Bus bundle between two hosts, the crossbar and two devices.
// Hosts sit on the master side; the crossbar uses the slave modport.
interface core_bus_xbar_if;
    logic [1:0]  host_req_i;
    logic [1:0]  host_gnt_o;
    logic [1:0]  host_we_i;
    logic [7:0]  host_be_i;
    logic [63:0] host_addr_i;
    logic [63:0] host_wdata_i;
    logic [1:0]  host_rvalid_o;
    logic [63:0] host_rdata_o;
    logic [1:0]  host_err_o;
    logic [1:0]  device_req_o;
    logic [1:0]  device_we_o;
    logic [7:0]  device_be_o;
    logic [63:0] device_addr_o;
    logic [63:0] device_wdata_o;
    logic [1:0]  device_rvalid_i;
    logic [63:0] device_rdata_i;

    modport slave (
        input  host_req_i, host_we_i, host_be_i,
        input  host_addr_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o,
        output host_rdata_o, host_err_o,
        output device_req_o, device_we_o, device_be_o,
        output device_addr_o, device_wdata_o,
        input  device_rvalid_i, device_rdata_i
    );

    modport master (
        output host_req_i, host_we_i, host_be_i,
        output host_addr_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o,
        input  host_rdata_o, host_err_o,
        input  device_req_o, device_we_o, device_be_o,
        input  device_addr_o, device_wdata_o,
        output device_rvalid_i, device_rdata_i
    );
endinterface

// File: rtl/core_bus_xbar.sv
// Two-host / two-device crossbar: fixed priority, address decode,
// single-cycle response routed back to the host that won.
module core_bus_xbar #(
    parameter logic [31:0] DEV0_BASE = 32'h0010_0000,
    parameter logic [31:0] DEV0_MASK = 32'hFFF0_0000,
    parameter logic [31:0] DEV1_BASE = 32'h0002_0000,
    parameter logic [31:0] DEV1_MASK = 32'hFFFF_FC00
) (
    input  logic clk_i,
    input  logic rst_ni,
    core_bus_xbar_if.slave bus
);
    logic [1:0]  gnt;
    logic        win;
    logic        we_w;
    logic [3:0]  be_w;
    logic [31:0] addr_w;
    logic [31:0] wdata_w;
    logic        hit0;
    logic        hit1;
    logic        unmap;
    logic        dsel;

    logic pend_q, pend_d;
    logic host_q, host_d;
    logic dev_q, dev_d;
    logic unmap_q, unmap_d;

    always_comb begin
        gnt = 2'b00;
        win = 1'b0;
        priority case (1'b1)
            bus.host_req_i[0]: gnt = 2'b01;
            bus.host_req_i[1]: begin
                gnt = 2'b10;
                win = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        we_w    = bus.host_we_i[win];
        be_w    = bus.host_be_i[{win, 2'b00} +: 4];
        addr_w  = bus.host_addr_i[{win, 5'b0} +: 32];
        wdata_w = bus.host_wdata_i[{win, 5'b0} +: 32];
    end

    // Device 0 wins an overlapping decode.
    always_comb begin
        hit0  = (addr_w & DEV0_MASK) == DEV0_BASE;
        hit1  = (addr_w & DEV1_MASK) == DEV1_BASE;
        dsel  = ~hit0 & hit1;
        unmap = ~hit0 & ~hit1;
    end

    always_comb begin
        bus.host_gnt_o      = gnt;
        bus.device_req_o    = 2'b00;
        bus.device_req_o[0] = (|gnt) & hit0;
        bus.device_req_o[1] = (|gnt) & dsel;
        bus.device_we_o     = {2{we_w}};
        bus.device_be_o     = {2{be_w}};
        bus.device_addr_o   = {2{addr_w}};
        bus.device_wdata_o  = {2{wdata_w}};
    end

    always_comb begin
        pend_d  = |gnt;
        host_d  = win;
        dev_d   = dsel;
        unmap_d = unmap;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q  <= 1'b0;
            host_q  <= 1'b0;
            dev_q   <= 1'b0;
            unmap_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            host_q  <= host_d;
            dev_q   <= dev_d;
            unmap_q <= unmap_d;
        end
    end

    // Responses are gated by pend so idle and reset outputs read zero.
    always_comb begin
        bus.host_rvalid_o = 2'b00;
        bus.host_err_o    = 2'b00;
        bus.host_rdata_o  = '0;
        if (pend_q) begin
            bus.host_rvalid_o[host_q] = 1'b1;
            bus.host_err_o[host_q] =
                unmap_q | ~bus.device_rvalid_i[dev_q];
            if (!unmap_q)
                bus.host_rdata_o[{host_q, 5'b0} +: 32] =
                    bus.device_rdata_i[{dev_q, 5'b0} +: 32];
        end
    end
endmodule

// File: tb/tb_core_bus_xbar.sv
// Directed bench for core_bus_xbar with two responding device models.
module tb_core_bus_xbar;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] den = 2'b11;
    logic [1:0] dvld = 2'b00;
    int errs = 0;
    int checks = 0;

    localparam logic [31:0] RD0 = 32'h1111_0000;
    localparam logic [31:0] RD1 = 32'h2222_0000;

    core_bus_xbar_if bus ();

    core_bus_xbar dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Devices answer one cycle after their request unless stubbed.
    always @(posedge clk) dvld <= bus.device_req_o & den;
    assign bus.device_rvalid_i = dvld;
    assign bus.device_rdata_i = {RD1, RD0};

    task automatic chk(string tag, logic [63:0] got,
                       logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drv(logic [1:0] req, logic [1:0] we,
                       logic [7:0] be, logic [31:0] a0,
                       logic [31:0] a1, logic [31:0] w0);
        bus.host_req_i   = req;
        bus.host_we_i    = we;
        bus.host_be_i    = be;
        bus.host_addr_i  = {a1, a0};
        bus.host_wdata_i = {32'h0, w0};
        #1;
    endtask

    logic [31:0] dec_addr [6];
    logic [1:0]  dec_req  [6];

    initial begin
        dec_addr[0] = 32'h0010_0000; dec_req[0] = 2'b01;
        dec_addr[1] = 32'h001F_FFFC; dec_req[1] = 2'b01;
        dec_addr[2] = 32'h0020_0000; dec_req[2] = 2'b00;
        dec_addr[3] = 32'h0002_03FC; dec_req[3] = 2'b10;
        dec_addr[4] = 32'h0002_0400; dec_req[4] = 2'b00;
        dec_addr[5] = 32'h0001_FFFC; dec_req[5] = 2'b00;

        drv(2'b00, 2'b00, 8'h0, 32'h0, 32'h0, 32'h0);
        tick(); tick();
        chk("rst_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        chk("rst_err", 64'(bus.host_err_o), 64'h0);
        chk("rst_rdata", bus.host_rdata_o, 64'h0);
        rst_n = 1'b1;
        tick();

        // host 0 writes 'A' to the console
        drv(2'b01, 2'b01, 8'h01, 32'h0002_0000, 32'h0, 32'h41);
        chk("t1_gnt", 64'(bus.host_gnt_o), 64'h1);
        chk("t1_dreq", 64'(bus.device_req_o), 64'h2);
        chk("t1_dwe", 64'(bus.device_we_o), 64'h3);
        chk("t1_dbe", 64'(bus.device_be_o[7:4]), 64'h1);
        chk("t1_daddr", 64'(bus.device_addr_o[63:32]),
            64'h0002_0000);
        chk("t1_char", 64'(bus.device_wdata_o[39:32]), 64'h41);
        tick();
        chk("t1_rvalid", 64'(bus.host_rvalid_o), 64'h1);
        chk("t1_err", 64'(bus.host_err_o), 64'h0);

        // both hosts request RAM, be=0 passes through
        drv(2'b11, 2'b00, 8'h00, 32'h0010_0004,
            32'h0010_0000, 32'h0);
        chk("t2_gnt", 64'(bus.host_gnt_o), 64'h1);
        chk("t2_dreq", 64'(bus.device_req_o), 64'h1);
        chk("t2_daddr", 64'(bus.device_addr_o[31:0]),
            64'h0010_0004);
        chk("t2_be0", 64'(bus.device_be_o), 64'h0);
        tick();
        chk("t2_rv0", 64'(bus.host_rvalid_o), 64'h1);
        chk("t2_rd0", bus.host_rdata_o, {32'h0, RD0});
        drv(2'b10, 2'b00, 8'hF0, 32'h0010_0004,
            32'h0010_0000, 32'h0);
        chk("t2_gnt1", 64'(bus.host_gnt_o), 64'h2);
        chk("t2_daddr1", 64'(bus.device_addr_o[31:0]),
            64'h0010_0000);
        chk("t2_dbe1", 64'(bus.device_be_o), 64'hFF);
        tick();
        chk("t2_rv1", 64'(bus.host_rvalid_o), 64'h2);
        chk("t2_rd1", bus.host_rdata_o, {RD0, 32'h0});
        chk("t2_err1", 64'(bus.host_err_o), 64'h0);

        // host 1 unmapped read
        drv(2'b10, 2'b00, 8'hF0, 32'h0, 32'h0000_1000, 32'h0);
        chk("t3_gnt", 64'(bus.host_gnt_o), 64'h2);
        chk("t3_dreq", 64'(bus.device_req_o), 64'h0);
        tick();
        chk("t3_rv", 64'(bus.host_rvalid_o), 64'h2);
        chk("t3_err", 64'(bus.host_err_o), 64'h2);
        chk("t3_rd", bus.host_rdata_o, 64'h0);

        // back-to-back d0 then d1
        drv(2'b01, 2'b00, 8'h0F, 32'h0010_0008, 32'h0, 32'h0);
        chk("t4_dreq0", 64'(bus.device_req_o), 64'h1);
        tick();
        chk("t4_rv0", 64'(bus.host_rvalid_o), 64'h1);
        chk("t4_rd0", bus.host_rdata_o, {32'h0, RD0});
        drv(2'b01, 2'b00, 8'h0F, 32'h0002_0004, 32'h0, 32'h0);
        chk("t4_dreq1", 64'(bus.device_req_o), 64'h2);
        tick();
        chk("t4_rv1", 64'(bus.host_rvalid_o), 64'h1);
        chk("t4_rd1", bus.host_rdata_o, {32'h0, RD1});
        chk("t4_err1", 64'(bus.host_err_o), 64'h0);

        // stubbed d0 never responds
        den = 2'b10;
        drv(2'b01, 2'b00, 8'h0F, 32'h0010_0000, 32'h0, 32'h0);
        tick();
        chk("t5_rv", 64'(bus.host_rvalid_o), 64'h1);
        chk("t5_err", 64'(bus.host_err_o), 64'h1);
        den = 2'b11;

        // decode boundaries
        for (int i = 0; i < 6; i++) begin
            drv(2'b01, 2'b00, 8'h0F, dec_addr[i], 32'h0, 32'h0);
            chk($sformatf("dec%0d_req", i),
                64'(bus.device_req_o), 64'(dec_req[i]));
            tick();
            chk($sformatf("dec%0d_err", i),
                64'(bus.host_err_o),
                64'(dec_req[i] == 2'b00));
        end

        // reset in the cycle after a grant
        drv(2'b01, 2'b00, 8'h0F, 32'h0010_0000, 32'h0, 32'h0);
        tick();
        rst_n = 1'b0;
        drv(2'b00, 2'b00, 8'h0, 32'h0, 32'h0, 32'h0);
        chk("t6_rv_rst", 64'(bus.host_rvalid_o), 64'h0);
        tick();
        chk("t6_rv_hold", 64'(bus.host_rvalid_o), 64'h0);
        rst_n = 1'b1;
        tick();
        chk("t6_rv_idle", 64'(bus.host_rvalid_o), 64'h0);
        drv(2'b10, 2'b00, 8'hF0, 32'h0, 32'h0002_0008, 32'h0);
        chk("t6_gnt", 64'(bus.host_gnt_o), 64'h2);
        chk("t6_dreq", 64'(bus.device_req_o), 64'h2);
        tick();
        chk("t6_rv", 64'(bus.host_rvalid_o), 64'h2);
        chk("t6_err", 64'(bus.host_err_o), 64'h0);
        chk("t6_rd", bus.host_rdata_o, {RD1, 32'h0});
        drv(2'b00, 2'b00, 8'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("idle_rv", 64'(bus.host_rvalid_o), 64'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
